otp_decryptor: RTL



---
 rtl/otp_decryptor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/otp_decryptor.sv
// Receive-side one-time-pad decryptor: regenerates the sender's pad stream with a
// local LFSR, keeps an 8-slot pad window and XORs each ciphertext byte with its pad.
module otp_decryptor #(
    parameter logic [7:0] SEED = 8'h01,
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       lost_pulse,
    output logic [7:0] lost_count,
    output logic       synced
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    function automatic logic [7:0] f_lfsr_step(input logic [7:0] q);
        return {q[6:0], ^(q & TAPS)};
    endfunction

    // Adds the skipped-frame distance to the lost counter, clamping at 8'hFF.
    function automatic logic [7:0] f_sat_add(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {6'b000000, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    state_t     r_state;
    logic [7:0] r_lfsr;
    logic [2:0] r_fill_ptr;
    logic [2:0] r_exp_idx;
    logic [2:0] r_end_idx;
    logic [7:0] r_slot [0:7];
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_lost_pulse;
    logic [7:0] r_lost_count;

    state_t     w_state_nxt;
    logic [7:0] w_lfsr_nxt;
    logic [2:0] w_fill_ptr_nxt;
    logic [2:0] w_exp_idx_nxt;
    logic [2:0] w_end_idx_nxt;
    logic       w_wr_en;
    logic [2:0] w_wr_idx;
    logic       w_out_valid_nxt;
    logic [7:0] w_out_data_nxt;
    logic       w_lost_pulse_nxt;
    logic [7:0] w_lost_count_nxt;
    logic       w_accept;
    logic [2:0] w_dist;

    assign in_ready   = ena && (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_dist     = in_idx - r_exp_idx;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign lost_pulse = r_lost_pulse;
    assign lost_count = r_lost_count;
    assign synced     = (r_state != ST_FILL);

    // Next-state logic: pad-window refill sequencing and output register loading.
    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = r_lfsr;
        w_fill_ptr_nxt   = r_fill_ptr;
        w_exp_idx_nxt    = r_exp_idx;
        w_end_idx_nxt    = r_end_idx;
        w_wr_en          = 1'b0;
        w_wr_idx         = r_exp_idx;
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_lost_pulse_nxt = 1'b0;
        w_lost_count_nxt = r_lost_count;

        unique case (r_state)
            ST_FILL: begin
                w_wr_en        = 1'b1;
                w_wr_idx       = r_fill_ptr;
                w_lfsr_nxt     = f_lfsr_step(r_lfsr);
                w_fill_ptr_nxt = r_fill_ptr + 3'd1;
                if (r_fill_ptr == 3'd7) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_RUN: begin
                if (w_accept && (w_dist == 3'd0)) begin
                    w_wr_en       = 1'b1;
                    w_lfsr_nxt    = f_lfsr_step(r_lfsr);
                    w_exp_idx_nxt = r_exp_idx + 3'd1;
                end else if (w_accept) begin
                    // Frames were lost: catch the pad stream up through in_idx.
                    w_lost_pulse_nxt = 1'b1;
                    w_lost_count_nxt = f_sat_add(r_lost_count, w_dist);
                    w_end_idx_nxt    = in_idx;
                    w_state_nxt      = ST_SKIP;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SKIP: begin
                w_wr_en       = 1'b1;
                w_lfsr_nxt    = f_lfsr_step(r_lfsr);
                w_exp_idx_nxt = r_exp_idx + 3'd1;
                if (r_exp_idx == r_end_idx) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_SKIP;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase

        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = in_data ^ r_slot[in_idx];
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end else begin
            w_out_valid_nxt = r_out_valid;
        end
    end

    // Control and output registers; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_lfsr       <= SEED;
            r_fill_ptr   <= 3'd0;
            r_exp_idx    <= 3'd0;
            r_end_idx    <= 3'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_lost_pulse <= 1'b0;
            r_lost_count <= 8'h00;
        end else if (ena) begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_fill_ptr   <= w_fill_ptr_nxt;
            r_exp_idx    <= w_exp_idx_nxt;
            r_end_idx    <= w_end_idx_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_lost_pulse <= w_lost_pulse_nxt;
            r_lost_count <= w_lost_count_nxt;
        end
    end

    // Pad window storage; slot k always holds a pad whose sequence number is k mod 8.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= 8'h00;
            end
        end else if (ena && w_wr_en) begin
            r_slot[w_wr_idx] <= r_lfsr;
        end
    end

endmodule
